// File: rtl/crc3_serial_checker_pkg.sv
// Shared constants and FSM state type for the serial CRC-3 checker.
// The DIVISOR default is shared with the combinational CRC generator.
package crc3_serial_checker_pkg;

    localparam int         BW_DEFAULT      = 4;
    localparam int         CRC_BW_DEFAULT  = 3;
    localparam logic [2:0] DIVISOR_DEFAULT = 3'b011;

    typedef enum logic {
        RECV = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/crc3_serial_checker_crc_serial_step.sv
// One step of a bit-serial polynomial divider: shift in a bit and
// subtract the generator when the bit falling off the top is set.
module crc_serial_step #(
    parameter int CRC_BW = 3
) (
    input  logic [CRC_BW-1:0] i_rem,
    input  logic              i_bit,
    input  logic [CRC_BW-1:0] i_divisor,
    output logic [CRC_BW-1:0] o_rem
);

    always_comb begin
        o_rem = {i_rem[CRC_BW-2:0], i_bit} ^ (i_rem[CRC_BW-1] ? i_divisor : '0);
    end

endmodule

// File: rtl/crc3_serial_checker.sv
// Bit-serial CRC checker: receives data bits then check bits MSB first,
// and presents the recovered data, syndrome and error flag on valid/ready.
module crc3_serial_checker
    import crc3_serial_checker_pkg::*;
#(
    parameter int                BW      = BW_DEFAULT,
    parameter int                CRC_BW  = CRC_BW_DEFAULT,
    parameter logic [CRC_BW-1:0] DIVISOR = DIVISOR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_bit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BW-1:0]     out_data,
    output logic [CRC_BW-1:0] out_syndrome,
    output logic              out_err
);

    localparam int              CNT_W    = $clog2(BW + CRC_BW);
    localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(BW);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BW + CRC_BW - 1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [CRC_BW-1:0]   r_rem;
    logic [BW-1:0]       r_data;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [BW-1:0]       r_out_data;
    logic [CRC_BW-1:0]   r_out_syndrome;
    logic                r_out_err;

    logic                w_accept;
    logic [CRC_BW-1:0]   w_rem_next;

    assign w_accept = in_valid && r_in_ready;

    crc_serial_step #(
        .CRC_BW (CRC_BW)
    ) u_step (
        .i_rem     (r_rem),
        .i_bit     (in_bit),
        .i_divisor (DIVISOR),
        .o_rem     (w_rem_next)
    );

    // The last bit's handshake latches the result directly from the divider's next value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= RECV;
            r_cnt          <= '0;
            r_rem          <= '0;
            r_data         <= '0;
            r_in_ready     <= 1'b1;
            r_out_valid    <= 1'b0;
            r_out_data     <= '0;
            r_out_syndrome <= '0;
            r_out_err      <= 1'b0;
        end else begin
            case (r_state)
                RECV: begin
                    if (w_accept) begin
                        if (r_cnt < DATA_CNT) begin
                            r_data <= {r_data[BW-2:0], in_bit};
                        end
                        if (r_cnt == LAST_CNT) begin
                            r_out_data     <= r_data;
                            r_out_syndrome <= w_rem_next;
                            r_out_err      <= |w_rem_next;
                            r_cnt          <= '0;
                            r_rem          <= '0;
                            r_state        <= HOLD;
                            r_in_ready     <= 1'b0;
                            r_out_valid    <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                            r_rem <= w_rem_next;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_state     <= RECV;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= RECV;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_syndrome = r_out_syndrome;
    assign out_err      = r_out_err;

endmodule

// File: tb/tb_crc3_serial_checker.sv
// Directed, table-driven bench for crc3_serial_checker (x^3+x+1, 4 data bits).
// Expected syndromes are hand-computed remainders of the received 7-bit codeword.
module tb_crc3_serial_checker;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_bit;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [2:0] out_syndrome;
    logic       out_err;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct {
        logic [6:0] code;
        logic [3:0] expData;
        logic [2:0] expSyn;
        logic       expErr;
    } vector_t;

    vector_t vecs[6];

    crc3_serial_checker dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_bit       (in_bit),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_syndrome (out_syndrome),
        .out_err      (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of input and return 1ns after the sampling edge.
    task automatic applyStimulus(input logic v, input logic b);
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic sendFrame(input logic [6:0] code, input bit gapped);
        for (int i = 6; i >= 0; i--) begin
            if (gapped && i < 6) begin
                repeat ($urandom_range(1, 3)) applyStimulus(1'b0, ~code[i]);
            end
            applyStimulus(1'b1, code[i]);
            if (i > 0) checkOutput("validEarly", {31'b0, out_valid}, 32'd0);
        end
    endtask

    task automatic checkResult(input logic [3:0] expData, input logic [2:0] expSyn, input logic expErr);
        checkOutput("outValid", {31'b0, out_valid}, 32'd1);
        checkOutput("inReadyHold", {31'b0, in_ready}, 32'd0);
        checkOutput("outData", {28'b0, out_data}, {28'b0, expData});
        checkOutput("outSyndrome", {29'b0, out_syndrome}, {29'b0, expSyn});
        checkOutput("outErr", {31'b0, out_err}, {31'b0, expErr});
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput("validDrop", {31'b0, out_valid}, 32'd0);
        checkOutput("inReadyBack", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{code: 7'b1001110, expData: 4'b1001, expSyn: 3'b000, expErr: 1'b0};
        vecs[1] = '{code: 7'b1001111, expData: 4'b1001, expSyn: 3'b001, expErr: 1'b1};
        vecs[2] = '{code: 7'b0001110, expData: 4'b0001, expSyn: 3'b101, expErr: 1'b1};
        vecs[3] = '{code: 7'b0000000, expData: 4'b0000, expSyn: 3'b000, expErr: 1'b0};
        vecs[4] = '{code: 7'b1101001, expData: 4'b1101, expSyn: 3'b000, expErr: 1'b0};
        vecs[5] = '{code: 7'b1101000, expData: 4'b1101, expSyn: 3'b001, expErr: 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rstInReady", {31'b0, in_ready}, 32'd1);
        checkOutput("rstOutValid", {31'b0, out_valid}, 32'd0);
        checkOutput("rstData", {28'b0, out_data}, 32'd0);
        checkOutput("rstSyn", {29'b0, out_syndrome}, 32'd0);
        checkOutput("rstErr", {31'b0, out_err}, 32'd0);

        for (int v = 0; v < 6; v++) begin
            sendFrame(vecs[v].code, 1'b0);
            checkResult(vecs[v].expData, vecs[v].expSyn, vecs[v].expErr);
            handshake();
        end

        // Backpressure: result held while in_bit toggles with in_valid high.
        sendFrame(7'b1001111, 1'b0);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, c[0]);
            checkResult(4'b1001, 3'b001, 1'b1);
        end
        handshake();
        sendFrame(7'b0000000, 1'b0);
        checkResult(4'b0000, 3'b000, 1'b0);
        handshake();

        sendFrame(7'b1001110, 1'b1);
        checkResult(4'b1001, 3'b000, 1'b0);
        handshake();

        // Mid-frame reset discards the partial frame.
        for (int i = 6; i >= 3; i--) begin
            applyStimulus(1'b1, vecs[0].code[i]);
        end
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        rst = 1'b0;
        checkOutput("midRstInReady", {31'b0, in_ready}, 32'd1);
        checkOutput("midRstOutValid", {31'b0, out_valid}, 32'd0);
        sendFrame(7'b0000000, 1'b0);
        checkResult(4'b0000, 3'b000, 1'b0);
        handshake();
        repeat (3) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("singleOutput", {31'b0, out_valid}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
